// File: rtl/miner_pkg.sv
// Shared types and constants for the SHA-256 double-hash miner datapath control.
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FOLD,
        RESULT
    } seq_state_t;

    localparam int unsigned MSG_W      = 2;
    localparam int unsigned SHA_ROUNDS = 64;

    localparam logic [MSG_W-1:0] MSG_HDR0   = 2'd0;
    localparam logic [MSG_W-1:0] MSG_HDR1   = 2'd1;
    localparam logic [MSG_W-1:0] MSG_DIGEST = 2'd2;

endpackage

// File: rtl/sha_job_sequencer_if.sv
// Job/result handshake and compression-core control bundle of the job sequencer.
interface sha_job_sequencer_if #(
    parameter int unsigned IDX_W = 7
);
    import miner_pkg::*;

    logic             job_valid;
    logic             job_ready;
    logic             job_reuse_mid;
    logic             abort;
    logic             core_load_iv;
    logic             core_load_mid;
    logic [MSG_W-1:0] core_msg_sel;
    logic             core_round_en;
    logic [IDX_W-1:0] round_idx;
    logic             core_fold;
    logic             mid_save;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    modport master (
        output job_valid, job_reuse_mid, abort, result_ready,
        input  job_ready, core_load_iv, core_load_mid, core_msg_sel, core_round_en,
               round_idx, core_fold, mid_save, result_valid, busy
    );

    modport slave (
        input  job_valid, job_reuse_mid, abort, result_ready,
        output job_ready, core_load_iv, core_load_mid, core_msg_sel, core_round_en,
               round_idx, core_fold, mid_save, result_valid, busy
    );

endinterface

// File: rtl/round_ctr.sv
// Round index counter: synchronous restart, enable, and a flag on the final round.
module round_ctr #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             last_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (restart) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign last_c = (idx == IDX_W'(ROUNDS - 1));

endmodule

// File: rtl/sha_job_sequencer.sv
// Drives one shared SHA-256 compression core through the three blocks of a bitcoin
// double hash, caching the block-0 midstate so nonce-only jobs can skip block 0.
module sha_job_sequencer
    import miner_pkg::*;
#(
    parameter int unsigned ROUNDS = SHA_ROUNDS,
    parameter int unsigned IDX_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    sha_job_sequencer_if.slave  bus
);

    seq_state_t       state_q, state_d;
    logic [MSG_W-1:0] blk_q, blk_d;
    logic             mid_valid_q, mid_valid_d;
    logic             ctr_restart_c;
    logic             ctr_en_c;
    logic             ctr_last_c;

    round_ctr #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) u_round_ctr (
        .clk     (clk),
        .rst     (rst),
        .restart (ctr_restart_c),
        .en      (ctr_en_c),
        .idx     (bus.round_idx),
        .last_c  (ctr_last_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            blk_q       <= MSG_HDR0;
            mid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            mid_valid_q <= mid_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        mid_valid_d = mid_valid_q;
        ctr_en_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    state_d = LOAD;
                    blk_d   = (bus.job_reuse_mid && mid_valid_q) ? MSG_HDR1 : MSG_HDR0;
                end
            end
            LOAD: state_d = ROUND;
            ROUND: begin
                ctr_en_c = !ctr_last_c;
                if (ctr_last_c) state_d = FOLD;
            end
            FOLD: begin
                if (blk_q == MSG_HDR0) mid_valid_d = 1'b1;
                if (blk_q == MSG_DIGEST) begin
                    state_d = RESULT;
                end else begin
                    blk_d   = blk_q + MSG_W'(1);
                    state_d = LOAD;
                end
            end
            RESULT: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                    blk_d   = MSG_HDR0;
                end
            end
            default: begin
                state_d = IDLE;
                blk_d   = MSG_HDR0;
            end
        endcase

        // Abort overrides every transition above, including fold bookkeeping and transfer.
        if (bus.abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            blk_d       = MSG_HDR0;
            mid_valid_d = 1'b0;
        end

        ctr_restart_c = (state_d == IDLE) || (state_d == LOAD);
    end

    // Strobes are registered decodes of the next state, so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.job_ready     <= 1'b1;
            bus.busy          <= 1'b0;
            bus.core_load_iv  <= 1'b0;
            bus.core_load_mid <= 1'b0;
            bus.core_round_en <= 1'b0;
            bus.core_fold     <= 1'b0;
            bus.mid_save      <= 1'b0;
            bus.result_valid  <= 1'b0;
        end else begin
            bus.job_ready     <= (state_d == IDLE);
            bus.busy          <= (state_d != IDLE);
            bus.core_load_iv  <= (state_d == LOAD) && (blk_d != MSG_HDR1);
            bus.core_load_mid <= (state_d == LOAD) && (blk_d == MSG_HDR1);
            bus.core_round_en <= (state_d == ROUND);
            bus.core_fold     <= (state_d == FOLD);
            bus.mid_save      <= (state_d == FOLD) && (blk_d == MSG_HDR0);
            bus.result_valid  <= (state_d == RESULT);
        end
    end

    assign bus.core_msg_sel = blk_q;

endmodule
